ula_seq: RTL and testbench

//  Parametrised, clocked successor to the single-width ALU. Performs unsigned

---
 rtl/ula_seq.sv | 120 ++++++++++++
 tb/tb_ula_seq.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/ula_seq.sv
// ula_seq: clocked ALU with shift-add multiply, add, sub and unsigned compare behind a start/busy/done handshake.
// Define EARLY_TERM_EN to end a multiply once the remaining multiplier bits are all zero.
module ula_seq #(
  parameter int WIDTH = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [1:0]       cmd_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] result_hi_o,
  output logic             carry_o,
  output logic             overflow_o,
  output logic             zero_o
);
  typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;
  state_t               state_q;
  logic [2*WIDTH-1:0]   mcand_q, acc_q, acc_d;
  logic [WIDTH-1:0]     mplier_q, result_q, result_hi_q;
  logic                 busy_q, done_q, carry_q, overflow_q, zero_q;
  logic                 sub, lt, ovf, last;
  logic [WIDTH:0]       sum;
  assign sub   = cmd_i == 2'b10;
  assign sum   = {1'b0, a_i} + {1'b0, sub ? ~b_i : b_i} + (WIDTH+1)'(sub);
  assign ovf   = (a_i[WIDTH-1] ~^ (sub ? ~b_i[WIDTH-1] : b_i[WIDTH-1])) & (sum[WIDTH-1] ^ a_i[WIDTH-1]);
  assign lt    = a_i < b_i;
  assign acc_d = mplier_q[0] ? acc_q + mcand_q : acc_q;
`ifdef EARLY_TERM_EN
  assign last = ~|mplier_q[WIDTH-1:1];
`else
  localparam int CW = $clog2(WIDTH + 1);
  logic [CW-1:0] cnt_q;
  assign last = cnt_q == CW'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (state_q == IDLE && start_i && cmd_i == 2'b00) cnt_q <= CW'(WIDTH);
    else if (state_q == MULT) cnt_q <= cnt_q - CW'(1);
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start_i) begin
          busy_q <= 1'b1;
          if (cmd_i == 2'b00) begin
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            mplier_q <= b_i;
            acc_q    <= '0;
`ifdef EARLY_TERM_EN
            if (b_i == '0) begin
              result_q    <= '0;
              result_hi_q <= '0;
              carry_q     <= 1'b0;
              overflow_q  <= 1'b0;
              zero_q      <= 1'b1;
              done_q      <= 1'b1;
              state_q     <= DONE;
            end else state_q <= MULT;
`else
            state_q  <= MULT;
`endif
          end else begin
            result_q    <= cmd_i == 2'b11 ? WIDTH'(lt) : sum[WIDTH-1:0];
            result_hi_q <= '0;
            carry_q     <= cmd_i == 2'b01 ? sum[WIDTH] : sub ? ~sum[WIDTH] : 1'b0;
            overflow_q  <= cmd_i != 2'b11 && ovf;
            zero_q      <= cmd_i == 2'b11 ? ~lt : sum[WIDTH-1:0] == '0;
            done_q      <= 1'b1;
            state_q     <= DONE;
          end
        end
        MULT: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          if (last) begin
            result_q    <= acc_d[WIDTH-1:0];
            result_hi_q <= acc_d[2*WIDTH-1:WIDTH];
            carry_q     <= |acc_d[2*WIDTH-1:WIDTH];
            overflow_q  <= 1'b0;
            zero_q      <= acc_d == '0;
            done_q      <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign result_o    = result_q;
  assign result_hi_o = result_hi_q;
  assign carry_o     = carry_q;
  assign overflow_o  = overflow_q;
  assign zero_o      = zero_q;
endmodule

// File: tb/tb_ula_seq.sv
// tb_ula_seq: directed and random checks of ula_seq (WIDTH=8) against an arithmetic reference model.
module tb_ula_seq;
  logic       clk = 1'b0, rst_n = 1'b0, start_i = 1'b0;
  logic [1:0] cmd_i = 2'b00;
  logic [7:0] a_i = '0, b_i = '0;
  logic       busy_o, done_o, carry_o, overflow_o, zero_o;
  logic [7:0] result_o, result_hi_o;
  int n_assert = 0, n_fail = 0;

  ula_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .cmd_i(cmd_i), .a_i(a_i), .b_i(b_i),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o), .result_hi_o(result_hi_o),
    .carry_o(carry_o), .overflow_o(overflow_o), .zero_o(zero_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [1:0] c, input logic [7:0] x, input logic [7:0] y,
                       output logic [7:0] er, output logic [7:0] eh, output logic ec,
                       output logic eo, output logic ez, output int el);
    int p, sx, sy, s;
    p  = int'(x) * int'(y);
    sx = x >= 128 ? int'(x) - 256 : int'(x);
    sy = y >= 128 ? int'(y) - 256 : int'(y);
    eh = '0; ec = 1'b0; eo = 1'b0; el = 1;
    if (c == 2'b00) begin
      er = 8'(p); eh = 8'(p >> 8); ec = eh != 0; ez = p == 0;
`ifdef EARLY_TERM_EN
      for (int i = 0; i < 8; i++) if (y[i]) el = i + 2;
`else
      el = 9;
`endif
    end else if (c == 2'b01) begin
      er = 8'(int'(x) + int'(y)); ec = int'(x) + int'(y) > 255;
      s = sx + sy; eo = s > 127 || s < -128; ez = er == 0;
    end else if (c == 2'b10) begin
      er = 8'(int'(x) - int'(y)); ec = x < y;
      s = sx - sy; eo = s > 127 || s < -128; ez = er == 0;
    end else begin
      er = x < y ? 8'd1 : 8'd0; ez = !(x < y);
    end
  endtask

  task automatic do_op(input logic [1:0] c, input logic [7:0] x, input logic [7:0] y);
    logic [7:0] er, eh;
    logic ec, eo, ez;
    int el, lat;
    model(c, x, y, er, eh, ec, eo, ez, el);
    @(negedge clk);
    start_i = 1'b1; cmd_i = c; a_i = x; b_i = y;
    @(posedge clk); #1;
    start_i = 1'b0; a_i = 8'($urandom); b_i = 8'($urandom); cmd_i = 2'($urandom);
    lat = 1;
    while (!done_o && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, el);
    chk("result", result_o, er);
    chk("result_hi", result_hi_o, eh);
    chk("carry", carry_o, ec);
    chk("overflow", overflow_o, eo);
    chk("zero", zero_o, ez);
    chk("busy_in_done", busy_o, 1'b1);
    @(posedge clk); #1;
    chk("done_one_cycle", done_o, 1'b0);
    chk("busy_after", busy_o, 1'b0);
    chk("result_hold", result_o, er);
  endtask

  initial begin
    logic [7:0] er, eh;
    logic ec, eo, ez;
    int el, lat, ndone;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy_o, 0); chk("rst_done", done_o, 0); chk("rst_result", result_o, 0);
    chk("rst_hi", result_hi_o, 0); chk("rst_carry", carry_o, 0); chk("rst_ovf", overflow_o, 0);
    chk("rst_zero", zero_o, 0);
    @(negedge clk); rst_n = 1'b1;

    do_op(2'b00, 8'd13, 8'd11);
    do_op(2'b00, 8'hFF, 8'hFF);
    do_op(2'b00, 8'h55, 8'h00);
    do_op(2'b00, 8'h00, 8'hA7);
    do_op(2'b01, 8'h7F, 8'h01);
    do_op(2'b01, 8'hFF, 8'h01);
    do_op(2'b10, 8'd3, 8'd5);
    do_op(2'b10, 8'h80, 8'h01);
    do_op(2'b11, 8'd3, 8'd5);
    do_op(2'b11, 8'd5, 8'd3);

    // abort a multiply with an asynchronous reset partway through
    @(negedge clk); start_i = 1'b1; cmd_i = 2'b00; a_i = 8'hC3; b_i = 8'hFF;
    @(posedge clk); #1; start_i = 1'b0;
    repeat (2) @(posedge clk);
    #1; chk("mid_busy", busy_o, 1'b1);
    chk("mid_hold", result_o, 8'h00);
    #2; rst_n = 1'b0;
    #1;
    chk("abort_busy", busy_o, 0); chk("abort_result", result_o, 0); chk("abort_hi", result_hi_o, 0);
    chk("abort_carry", carry_o, 0); chk("abort_ovf", overflow_o, 0); chk("abort_zero", zero_o, 0);
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin @(posedge clk); #1; if (done_o) ndone++; end
    chk("abort_no_done", ndone, 0);
    do_op(2'b00, 8'd200, 8'd3);

    // start held high, operands toggled while multiplying, then a back-to-back add
    model(2'b00, 8'd29, 8'd97, er, eh, ec, eo, ez, el);
    @(negedge clk); start_i = 1'b1; cmd_i = 2'b00; a_i = 8'd29; b_i = 8'd97;
    @(posedge clk); #1;
    lat = 1; ndone = 0;
    while (!done_o && lat < 40) begin
      a_i = 8'($urandom); b_i = 8'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    chk("held_latency", lat, el);
    chk("held_result", result_o, er);
    chk("held_hi", result_hi_o, eh);
    a_i = 8'd100; b_i = 8'd27; cmd_i = 2'b01;
    @(posedge clk); #1;
    chk("held_drop_done", done_o, 0);
    chk("held_drop_busy", busy_o, 0);
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("b2b_done", done_o, 1);
    chk("b2b_result", result_o, 8'd127);
    chk("b2b_carry", carry_o, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) do_op(2'($urandom), 8'($urandom), 8'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
